// File: rtl/u712_pkg.sv
// u712_pkg: shared types and constants for the U712 register cycle arbiter.
package u712_pkg;
    typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT_TA, RELEASE} state_t;
    localparam int ARB_MODE_RR = 0;
    localparam int ARB_MODE_FIXED = 1;
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;
endpackage

// File: rtl/u712_sync2.sv
// u712_sync2: two-flop synchronizer with asynchronous active-low reset to 0.
module u712_sync2 (
    input  logic CLK40,
    input  logic nRESET,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge CLK40 or negedge nRESET)
        if (!nRESET) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
endmodule

// File: rtl/u712_regcycle_arbiter.sv
// u712_regcycle_arbiter: shares the chipset register cycle engine between CPU (A) and PCI (B).
// Define REG_TIMEOUT_EN to abort a WAIT_TA that exceeds TIMEOUT_CLKS with ACK+ERR.
module u712_regcycle_arbiter
    import u712_pkg::*;
#(
    parameter int ARB_MODE = ARB_MODE_RR,
    parameter int TIMEOUT_CLKS = 2047
) (
    input  logic       CLK40,
    input  logic       nRESET,
    input  logic       A_REQ,
    input  logic       A_RnW,
    input  logic [1:0] A_SIZ,
    input  logic [1:0] A_ADR,
    input  logic       B_REQ,
    input  logic       B_RnW,
    input  logic [1:0] B_SIZ,
    input  logic [1:0] B_ADR,
    input  logic       REG_TA,
    output logic       nREGSPACE,
    output logic       ENG_RnW,
    output logic [1:0] ENG_SIZ,
    output logic [1:0] ENG_ADR,
    output logic       A_ACK,
    output logic       B_ACK,
    output logic       GNT_B,
    output logic       BUSY,
    output logic       ERR
);
    state_t state;
    logic last_b, ta_s, ta_d, ta_rise, win_b, grant_req, tmo;
    if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 2047) begin : g_tmo_range
        $error("TIMEOUT_CLKS must fit the 11-bit counter");
    end
    u712_sync2 u_ta_sync (.CLK40(CLK40), .nRESET(nRESET), .d(REG_TA), .q(ta_s));
    always_ff @(posedge CLK40 or negedge nRESET)
        if (!nRESET) ta_d <= 1'b0;
        else ta_d <= ta_s;
    assign ta_rise = ta_s & ~ta_d;
    // On a round-robin tie B wins only when A was served last.
    assign win_b = B_REQ && (!A_REQ || (ARB_MODE != ARB_MODE_FIXED && !last_b));
    assign grant_req = GNT_B ? B_REQ : A_REQ;
`ifdef REG_TIMEOUT_EN
    logic [10:0] cnt;
    always_ff @(posedge CLK40 or negedge nRESET)
        if (!nRESET) cnt <= '0;
        else cnt <= (state == WAIT_TA) ? cnt + 11'd1 : '0;
    assign tmo = (state == WAIT_TA) && (cnt == 11'(TIMEOUT_CLKS - 1));
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
            nREGSPACE <= 1'b1;
            {ENG_RnW, ENG_SIZ, ENG_ADR} <= '0;
            {A_ACK, B_ACK, GNT_B, BUSY, ERR} <= '0;
            last_b <= 1'b1;
        end else begin
            A_ACK <= 1'b0;
            B_ACK <= 1'b0;
            ERR <= 1'b0;
            case (state)
                IDLE: if (A_REQ || B_REQ) begin
                    state <= ARB;
                    BUSY <= 1'b1;
                end
                ARB: if (A_REQ || B_REQ) begin
                    state <= LAUNCH;
                    GNT_B <= win_b;
                    last_b <= win_b;
                    {ENG_RnW, ENG_SIZ, ENG_ADR} <= win_b ? {B_RnW, B_SIZ, B_ADR} : {A_RnW, A_SIZ, A_ADR};
                end else begin
                    state <= IDLE;
                    BUSY <= 1'b0;
                end
                LAUNCH: begin
                    nREGSPACE <= 1'b0;
                    state <= WAIT_TA;
                end
                WAIT_TA: if (ta_rise || tmo) begin
                    nREGSPACE <= 1'b1;
                    A_ACK <= ~GNT_B;
                    B_ACK <= GNT_B;
                    ERR <= tmo;
                    state <= RELEASE;
                end
                RELEASE: if (!grant_req) begin
                    state <= IDLE;
                    BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
